// File: rtl/lane_distributor_p.sv
// Symbol-interleaves NUM_WORDS RS codewords across NUM_LANES PMA lanes and
// serialises each lane in OUT_SYMS-symbol chunks, flagging AM beats on chunk 0.
module lane_distributor_p #(
  parameter int unsigned SYM_WIDTH     = 10,
  parameter int unsigned NUM_WORDS     = 4,
  parameter int unsigned SYMS_PER_WORD = 544,
  parameter int unsigned NUM_LANES     = 16,
  parameter int unsigned OUT_SYMS      = 34,
  parameter int unsigned AM_PERIOD     = 4096
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            i_valid,
  output logic                                            o_ready,
  input  logic [NUM_WORDS*SYMS_PER_WORD*SYM_WIDTH-1:0]    i_word,
  output logic                                            o_valid,
  input  logic                                            i_ready,
  output logic [NUM_LANES*OUT_SYMS*SYM_WIDTH-1:0]         o_lanes,
  output logic [NUM_LANES-1:0]                            o_sync
);

  localparam int unsigned TOTAL_SYMS    = NUM_WORDS * SYMS_PER_WORD;
  localparam int unsigned SYMS_PER_LANE = TOTAL_SYMS / NUM_LANES;
  localparam int unsigned NCHUNK        = SYMS_PER_LANE / OUT_SYMS;
  localparam int unsigned CHUNK_WIDTH   = OUT_SYMS * SYM_WIDTH;
  localparam int unsigned BUF_WIDTH     = TOTAL_SYMS * SYM_WIDTH;
  localparam int unsigned CW            = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned BW            = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
  localparam logic [CW-1:0] LAST_CHUNK  = CW'(NCHUNK - 1);
  localparam logic [BW-1:0] LAST_BEAT   = BW'(AM_PERIOD - 1);

  if ((TOTAL_SYMS % NUM_LANES) != 0) begin : g_chk_lanes
    $error("NUM_WORDS*SYMS_PER_WORD must be divisible by NUM_LANES");
  end
  if ((SYMS_PER_LANE % OUT_SYMS) != 0) begin : g_chk_chunks
    $error("OUT_SYMS must divide SYMS_PER_LANE");
  end

  typedef enum logic {S_EMPTY, S_SEND} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          chunk_q, chunk_d;
  logic [BW-1:0]          beat_q,  beat_d;
  logic                   am_q,    am_d;
  logic [BUF_WIDTH-1:0]   buf_q,   buf_d;
  logic [BUF_WIDTH-1:0]   mapped;
  logic                   last;
  logic                   load;

  // Lane-major buffer: lane l, position p at symbol slot l*SYMS_PER_LANE+p,
  // so each chunk is one contiguous slice.
  always_comb begin
    mapped = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      for (int unsigned p = 0; p < SYMS_PER_LANE; p++) begin
        mapped[(l*SYMS_PER_LANE + p)*SYM_WIDTH +: SYM_WIDTH] =
          i_word[(((p*NUM_LANES + l) % NUM_WORDS)*SYMS_PER_WORD
                  + (p*NUM_LANES + l) / NUM_WORDS)*SYM_WIDTH +: SYM_WIDTH];
      end
    end
  end

  assign last    = (chunk_q == LAST_CHUNK);
  assign o_ready = !rst && ((state_q == S_EMPTY) || (last && i_ready));
  assign o_valid = (state_q == S_SEND);
  assign o_sync  = {NUM_LANES{(state_q == S_SEND) && (chunk_q == '0) && am_q}};

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    load    = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (i_valid) begin
          load    = 1'b1;
          chunk_d = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (i_ready) begin
          if (last) begin
            chunk_d = '0;
            if (i_valid) load    = 1'b1;
            else         state_d = S_EMPTY;
          end else begin
            chunk_d = chunk_q + 1'b1;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    buf_d  = buf_q;
    am_d   = am_q;
    beat_d = beat_q;
    if (load) begin
      buf_d  = mapped;
      am_d   = (beat_q == '0);
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end
  end

  always_comb begin
    o_lanes = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      o_lanes[l*CHUNK_WIDTH +: CHUNK_WIDTH] =
        buf_q[(l*SYMS_PER_LANE + int'(chunk_q)*OUT_SYMS)*SYM_WIDTH +: CHUNK_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      chunk_q <= '0;
      beat_q  <= '0;
      am_q    <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      beat_q  <= beat_d;
      am_q    <= am_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_lane_distributor_p.sv
// Directed bench for lane_distributor_p in the small 8-lane, 2-chunk configuration.
module tb_lane_distributor_p;

  localparam int SW = 10, NW = 4, SPW = 8, NL = 8, OS = 2, AMP = 3;
  localparam int CHW = OS * SW;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_valid;
  logic                   o_ready;
  logic [NW*SPW*SW-1:0]   i_word;
  logic                   o_valid;
  logic                   i_ready;
  logic [NL*CHW-1:0]      o_lanes;
  logic [NL-1:0]          o_sync;

  int checks = 0;
  int errors = 0;

  lane_distributor_p #(
    .SYM_WIDTH(SW), .NUM_WORDS(NW), .SYMS_PER_WORD(SPW),
    .NUM_LANES(NL), .OUT_SYMS(OS), .AM_PERIOD(AMP)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_word(i_word), .o_valid(o_valid), .i_ready(i_ready),
    .o_lanes(o_lanes), .o_sync(o_sync)
  );

  always #5 clk = ~clk;

  function automatic logic [NW*SPW*SW-1:0] mk(input int base);
    logic [NW*SPW*SW-1:0] r;
    r = '0;
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < SPW; s++)
        r[(w*SPW+s)*SW +: SW] = 10'(base + w*SPW + s);
    return r;
  endfunction

  function automatic logic [CHW-1:0] expc(input int base, input int l, input int c);
    logic [CHW-1:0] r;
    int p, g;
    r = '0;
    for (int j = 0; j < OS; j++) begin
      p = c*OS + j;
      g = p*NL + l;
      r[j*SW +: SW] = 10'(base + (g % NW)*SPW + g / NW);
    end
    return r;
  endfunction

  function automatic logic [CHW-1:0] pair(input int hi, input int lo);
    return {10'(hi), 10'(lo)};
  endfunction

  function automatic logic [CHW-1:0] lane(input int l);
    return o_lanes[l*CHW +: CHW];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_word = '0;
    @(negedge clk); #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_sync",  64'(o_sync),  64'd0);
    check("rst_lanes", 64'(o_lanes === '0), 64'd1);
    @(negedge clk); rst = 1'b0; #1;
    check("idle_ready", 64'(o_ready), 64'd1);

    // Mapping, one beat
    i_word = mk(0); i_valid = 1'b1; i_ready = 1'b1;
    @(negedge clk); i_valid = 1'b0; #1;
    check("map_valid", 64'(o_valid), 64'd1);
    check("map_c0_l0", 64'(lane(0)), 64'(pair(2, 0)));
    check("map_c0_l4", 64'(lane(4)), 64'(pair(3, 1)));
    check("map_c0_l1", 64'(lane(1)), 64'(pair(10, 8)));
    check("map_c0_sync", 64'(o_sync), 64'hFF);
    check("map_c0_ready", 64'(o_ready), 64'd0);
    @(negedge clk); #1;
    check("map_c1_l0", 64'(lane(0)), 64'(pair(6, 4)));
    check("map_c1_l4", 64'(lane(4)), 64'(pair(7, 5)));
    check("map_c1_l7", 64'(lane(7)), 64'(pair(31, 29)));
    check("map_c1_sync", 64'(o_sync), 64'h00);
    check("map_c1_ready", 64'(o_ready), 64'd1);
    @(negedge clk); #1;
    check("map_done_valid", 64'(o_valid), 64'd0);

    // Restart the AM period, then six back-to-back beats
    rst = 1'b1; #1; rst = 1'b0;
    i_word = mk(0); i_valid = 1'b1; i_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      i_word  = mk(((k / 2) + 1) * 32);
      i_valid = (k < 11);
      #1;
      check($sformatf("b2b_valid_%0d", k), 64'(o_valid), 64'd1);
      check($sformatf("b2b_ready_%0d", k), 64'(o_ready), 64'((k % 2) == 1));
      check($sformatf("b2b_sync_%0d", k), 64'(o_sync), (k == 0 || k == 6) ? 64'hFF : 64'h00);
      check($sformatf("b2b_l3_%0d", k), 64'(lane(3)), 64'(expc((k / 2) * 32, 3, k % 2)));
    end
    @(negedge clk); #1;
    check("b2b_end_valid", 64'(o_valid), 64'd0);
    check("b2b_end_ready", 64'(o_ready), 64'd1);

    // Backpressure during chunk 0 (beat counter back at 0: AM beat)
    i_word = mk(0); i_valid = 1'b1; i_ready = 1'b1;
    @(negedge clk); i_valid = 1'b0; i_ready = 1'b0; i_word = mk(500); #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_l0_%0d", k), 64'(lane(0)), 64'(pair(2, 0)));
      check($sformatf("bp_sync_%0d", k), 64'(o_sync), 64'hFF);
      check($sformatf("bp_ready_%0d", k), 64'(o_ready), 64'd0);
      check($sformatf("bp_valid_%0d", k), 64'(o_valid), 64'd1);
      @(negedge clk); #1;
    end
    i_ready = 1'b1; #1;
    check("bp_ret_l0", 64'(lane(0)), 64'(pair(2, 0)));
    check("bp_ret_ready", 64'(o_ready), 64'd0);
    @(negedge clk); #1;
    check("bp_c1_l0", 64'(lane(0)), 64'(pair(6, 4)));
    check("bp_c1_sync", 64'(o_sync), 64'h00);
    check("bp_c1_ready", 64'(o_ready), 64'd1);

    // Idle gap, then a non-AM beat (counter now 1)
    @(negedge clk); #1;
    check("gap_valid", 64'(o_valid), 64'd0);
    check("gap_ready", 64'(o_ready), 64'd1);
    repeat (3) begin
      @(negedge clk); i_word = mk(700); #1;
      check("gap_hold_valid", 64'(o_valid), 64'd0);
    end
    i_word = mk(64); i_valid = 1'b1;
    @(negedge clk); i_valid = 1'b0; i_word = mk(300); #1;
    check("gap_c0_valid", 64'(o_valid), 64'd1);
    check("gap_c0_l0", 64'(lane(0)), 64'(pair(66, 64)));
    check("gap_c0_sync", 64'(o_sync), 64'h00);
    @(negedge clk); #1;
    check("gap_c1_l0", 64'(lane(0)), 64'(pair(70, 68)));

    // Reset during chunk 1
    rst = 1'b1; #1;
    check("mrst_valid", 64'(o_valid), 64'd0);
    check("mrst_sync",  64'(o_sync),  64'd0);
    check("mrst_ready", 64'(o_ready), 64'd0);
    check("mrst_lanes", 64'(o_lanes === '0), 64'd1);
    @(negedge clk); rst = 1'b0; i_word = mk(0); i_valid = 1'b1;
    @(negedge clk); i_valid = 1'b0; #1;
    check("post_valid", 64'(o_valid), 64'd1);
    check("post_sync",  64'(o_sync),  64'hFF);
    check("post_l0",    64'(lane(0)), 64'(pair(2, 0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
